// File: rtl/add_share_arb.sv
// add_share_arb: two requesters time-share one 32-bit CLA adder (round-robin, IDLE->EXEC->RESP).
// Ports: clk, rst_n (async active-low); req_valid/req_ready[1:0] request handshake;
//   req_a0/req_b0/req_a1/req_b1 operands; req_sub[1:0] subtract request per requester;
//   rsp_valid/rsp_ready[1:0] response handshake; rsp_sum/rsp_cout/rsp_ovf shared result bus.
// Param RR_INIT: requester holding priority after reset.
// Macro ADD_SHARE_ARB_SUB_EN: enables A-B via inverted B and Cin=1; otherwise req_sub is ignored.
module cla_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [31:0] g, p;
  logic [32:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  for (genvar k = 0; k < 8; k++) begin : grp
    localparam int O = 4 * k;
    assign c[O+1] = g[O] | (p[O] & c[O]);
    assign c[O+2] = g[O+1] | (p[O+1] & g[O]) | (p[O+1] & p[O] & c[O]);
    assign c[O+3] = g[O+2] | (p[O+2] & g[O+1]) | (p[O+2] & p[O+1] & g[O])
                  | (p[O+2] & p[O+1] & p[O] & c[O]);
    assign c[O+4] = g[O+3] | (p[O+3] & g[O+2]) | (p[O+3] & p[O+2] & g[O+1])
                  | (p[O+3] & p[O+2] & p[O+1] & g[O]) | (p[O+3] & p[O+2] & p[O+1] & p[O] & c[O]);
  end
  assign s = p ^ c[31:0];
  assign cout = c[32];
endmodule

module add_share_arb #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_sub,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0]  state, grant;
  logic [31:0] a_r, b_r, bx, s;
  logic        owner, prio, cin, cout;
`ifdef ADD_SHARE_ARB_SUB_EN
  logic sub_r;
  assign bx = sub_r ? ~b_r : b_r;
  assign cin = sub_r;
`else
  logic unused_sub;
  assign unused_sub = ^req_sub;
  assign bx = b_r;
  assign cin = 1'b0;
`endif
  // Contention resolved by priority holder; a lone requester passes straight through.
  assign grant = (&req_valid) ? (prio ? 2'b10 : 2'b01) : req_valid;
  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  cla_adder u_add (.a(a_r), .b(bx), .cin(cin), .s(s), .cout(cout));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
`ifdef ADD_SHARE_ARB_SUB_EN
      sub_r <= 1'b0;
`endif
      owner <= 1'b0;
      prio <= RR_INIT != 0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf <= 1'b0;
    end else if (state == IDLE && |grant) begin
      a_r <= grant[1] ? req_a1 : req_a0;
      b_r <= grant[1] ? req_b1 : req_b0;
`ifdef ADD_SHARE_ARB_SUB_EN
      sub_r <= grant[1] ? req_sub[1] : req_sub[0];
`endif
      owner <= grant[1];
      state <= EXEC;
    end else if (state == EXEC) begin
      rsp_sum <= s;
      rsp_cout <= cout;
      rsp_ovf <= (a_r[31] == bx[31]) & (s[31] != a_r[31]);
      state <= RESP;
    end else if (state == RESP && rsp_ready[owner]) begin
      prio <= ~owner;
      state <= IDLE;
    end else if (state != IDLE && state != EXEC && state != RESP) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: randomized self-checking bench for add_share_arb against a transaction-level model.
module tb_add_share_arb;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;
  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_sum;
  logic        rsp_cout, rsp_ovf;
  logic        rr;
  int          checks, errors;

  add_share_arb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sub(req_sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint r;
    logic [31:0] sum;
    logic c, eff;
`ifdef ADD_SHARE_ARB_SUB_EN
    eff = sub;
`else
    eff = 1'b0 & sub;
`endif
    if (eff) begin
      sum = a - b;
      c = a >= b;
      r = longint'($signed(a)) - longint'($signed(b));
    end else begin
      sum = a + b;
      c = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF;
      r = longint'($signed(a)) + longint'($signed(b));
    end
    return {(r > SMAX) || (r < SMIN), c, sum};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] k[4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0};
    return ($urandom_range(0, 3) == 0) ? k[$urandom_range(0, 3)] : $urandom;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_op(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] sub,
                       input int hold);
    logic [1:0] g, oh;
    logic own;
    logic [33:0] e;
    req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1; req_sub = sub;
    rsp_ready = 2'b00;
    #1;
    g = (v == 2'b11) ? (rr ? 2'b10 : 2'b01) : v;
    check("grant", req_ready, g);
    if (g == 2'b00) begin
      @(posedge clk); #1;
      return;
    end
    own = g[1];
    oh = own ? 2'b10 : 2'b01;
    e = ref_op(own ? a1 : a0, own ? b1 : b0, sub[own]);
    @(posedge clk); #1;
    req_valid = 2'($urandom); req_a0 = $urandom; req_b0 = $urandom;
    req_a1 = $urandom; req_b1 = $urandom; req_sub = 2'($urandom);
    #1;
    check("exec_ready", req_ready, 2'b00);
    check("exec_valid", rsp_valid, 2'b00);
    @(posedge clk); #1;
    check("rsp_valid", rsp_valid, oh);
    check("rsp_sum", rsp_sum, e[31:0]);
    check("rsp_cout", rsp_cout, e[32]);
    check("rsp_ovf", rsp_ovf, e[33]);
    check("resp_ready", req_ready, 2'b00);
    repeat (hold) begin
      rsp_ready = own ? {1'b0, 1'($urandom)} : {1'($urandom), 1'b0};
      req_valid = 2'($urandom);
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, oh);
      check("hold_sum", rsp_sum, e[31:0]);
      check("hold_ready", req_ready, 2'b00);
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    rr = ~own;
    check("done_valid", rsp_valid, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; rr = 1'b0;
    rst_n = 1'b0; req_valid = 2'b00; req_sub = 2'b00; rsp_ready = 2'b00;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    #12;
    check("rst_valid", rsp_valid, 2'b00);
    check("rst_sum", rsp_sum, 32'h0);
    check("rst_cout", rsp_cout, 1'b0);
    check("rst_ovf", rsp_ovf, 1'b0);
    check("rst_ready", req_ready, 2'b00);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b11, 1, 1, 2, 2, 2'b00, 0);
    do_op(2'b11, 1, 1, 2, 2, 2'b00, 0);
    do_op(2'b01, 5, 7, 0, 0, 2'b00, 1);
    do_op(2'b01, 32'hFFFFFFFF, 1, 0, 0, 2'b00, 0);
    do_op(2'b10, 0, 0, 32'h7FFFFFFF, 1, 2'b00, 0);
    do_op(2'b01, 3, 5, 0, 0, 2'b01, 0);
    do_op(2'b10, 0, 0, 3, 5, 2'b10, 10);
    do_op(2'b00, 0, 0, 0, 0, 2'b00, 0);
    // reset while the operation is in EXEC
    req_valid = 2'b01; req_a0 = 9; req_b0 = 9;
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 2'b00);
    check("mid_rst_sum", rsp_sum, 32'h0);
    check("mid_rst_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_valid", rsp_valid, 2'b00);
    end
    for (int i = 0; i < 150; i++)
      do_op(2'($urandom), rnd_opnd(), rnd_opnd(), rnd_opnd(), rnd_opnd(), 2'($urandom),
            $urandom_range(0, 3));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
